// File: rtl/branch_predictor.sv
// Fetch-side gshare direction predictor with a direct-mapped BTB.
// Lookup is purely combinational on F_pc; all training comes from the execute update port.
module branch_predictor #(
    parameter int unsigned PHT_BITS = 8,
    parameter int unsigned BTB_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         F_pc,
    output logic                F_pred_taken,
    output logic [PHT_BITS-1:0] F_pht_idx,
    output logic                F_btb_hit,
    output logic [31:0]         F_btb_target,
    output logic [31:0]         F_pred_pc,
    input  logic                ex_update_en,
    input  logic                ex_is_cond,
    input  logic                ex_actual_taken,
    input  logic [31:0]         ex_pc,
    input  logic [31:0]         ex_actual_target,
    input  logic [PHT_BITS-1:0] ex_pht_idx,
    input  logic                ex_mispredict,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_mispredicts
);

    localparam int PhtEntries = 1 << PHT_BITS;
    localparam int BtbEntries = 1 << BTB_BITS;
    localparam int TagW       = 30 - BTB_BITS;

    logic [1:0]          pht_q        [PhtEntries];
    logic [PHT_BITS-1:0] ghr_q;
    logic                btb_valid_q  [BtbEntries];
    logic [TagW-1:0]     btb_tag_q    [BtbEntries];
    logic [31:0]         btb_target_q [BtbEntries];
    logic                btb_jump_q   [BtbEntries];
    logic [31:0]         perf_branches_q, perf_mispredicts_q;

    logic [1:0]          pht_cur, pht_d;
    logic [PHT_BITS-1:0] ghr_d;
    logic [31:0]         perf_branches_d, perf_mispredicts_d;

    logic [BTB_BITS-1:0] f_bi, ex_bi;
    logic [TagW-1:0]     f_tag, ex_tag;
    logic                unused_ex_pc_lsb;

    assign f_bi             = F_pc[BTB_BITS+1:2];
    assign f_tag            = F_pc[31:BTB_BITS+2];
    assign ex_bi            = ex_pc[BTB_BITS+1:2];
    assign ex_tag           = ex_pc[31:BTB_BITS+2];
    assign unused_ex_pc_lsb = ^ex_pc[1:0];

    // Lookup: no BTB hit means no known target, so never predict taken.
    always_comb begin
        F_pht_idx    = F_pc[PHT_BITS+1:2] ^ ghr_q;
        F_btb_hit    = btb_valid_q[f_bi] && (btb_tag_q[f_bi] == f_tag);
        F_btb_target = F_btb_hit ? btb_target_q[f_bi] : 32'd0;
        F_pred_taken = F_btb_hit && (btb_jump_q[f_bi] || pht_q[F_pht_idx][1]);
        F_pred_pc    = F_pred_taken ? F_btb_target : (F_pc + 32'd4);
    end

    always_comb begin
        pht_cur = pht_q[ex_pht_idx];
        pht_d   = pht_cur;
        if (ex_actual_taken) begin
            if (pht_cur != 2'b11) pht_d = pht_cur + 2'b01;
        end else begin
            if (pht_cur != 2'b00) pht_d = pht_cur - 2'b01;
        end
        ghr_d              = {ghr_q[PHT_BITS-2:0], ex_actual_taken};
        perf_branches_d    = perf_branches_q + 32'd1;
        perf_mispredicts_d = perf_mispredicts_q + {31'd0, ex_mispredict};
    end

    // Reset wins over a coincident update; the update is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PhtEntries; i++) begin
                pht_q[i] <= 2'b01;
            end
            for (int j = 0; j < BtbEntries; j++) begin
                btb_valid_q[j]  <= 1'b0;
                btb_tag_q[j]    <= '0;
                btb_target_q[j] <= 32'd0;
                btb_jump_q[j]   <= 1'b0;
            end
            ghr_q              <= '0;
            perf_branches_q    <= 32'd0;
            perf_mispredicts_q <= 32'd0;
        end else if (ex_update_en) begin
            if (ex_is_cond) begin
                pht_q[ex_pht_idx] <= pht_d;
                ghr_q             <= ghr_d;
            end
            if (ex_actual_taken) begin
                btb_valid_q[ex_bi]  <= 1'b1;
                btb_tag_q[ex_bi]    <= ex_tag;
                btb_target_q[ex_bi] <= ex_actual_target;
                btb_jump_q[ex_bi]   <= !ex_is_cond;
            end
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: one task per scenario.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] F_pc;
    logic        F_pred_taken;
    logic [7:0]  F_pht_idx;
    logic        F_btb_hit;
    logic [31:0] F_btb_target;
    logic [31:0] F_pred_pc;
    logic        ex_update_en;
    logic        ex_is_cond;
    logic        ex_actual_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_actual_target;
    logic [7:0]  ex_pht_idx;
    logic        ex_mispredict;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int n_vec = 0;
    int n_err = 0;

    branch_predictor #(.PHT_BITS(8), .BTB_BITS(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .F_pc             (F_pc),
        .F_pred_taken     (F_pred_taken),
        .F_pht_idx        (F_pht_idx),
        .F_btb_hit        (F_btb_hit),
        .F_btb_target     (F_btb_target),
        .F_pred_pc        (F_pred_pc),
        .ex_update_en     (ex_update_en),
        .ex_is_cond       (ex_is_cond),
        .ex_actual_taken  (ex_actual_taken),
        .ex_pc            (ex_pc),
        .ex_actual_target (ex_actual_target),
        .ex_pht_idx       (ex_pht_idx),
        .ex_mispredict    (ex_mispredict),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_update(input logic cond, input logic taken, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic [7:0] idx, input logic mp);
        ex_update_en     = 1'b1;
        ex_is_cond       = cond;
        ex_actual_taken  = taken;
        ex_pc            = pc;
        ex_actual_target = tgt;
        ex_pht_idx       = idx;
        ex_mispredict    = mp;
        @(posedge clk); #1;
        ex_update_en  = 1'b0;
        ex_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        F_pc = 32'h100; #1;
        n_vec++; if (F_btb_hit !== 1'b0) begin n_err++;
            $display("FAIL cold_hit got %0b want 0", F_btb_hit); end
        n_vec++; if (F_pred_taken !== 1'b0) begin n_err++;
            $display("FAIL cold_taken got %0b want 0", F_pred_taken); end
        n_vec++; if (F_pred_pc !== 32'h104) begin n_err++;
            $display("FAIL cold_pred_pc got %h want 00000104", F_pred_pc); end
        n_vec++; if (F_pht_idx !== 8'h40) begin n_err++;
            $display("FAIL cold_idx got %h want 40", F_pht_idx); end
        n_vec++; if (F_btb_target !== 32'h0) begin n_err++;
            $display("FAIL cold_target got %h want 0", F_btb_target); end
        n_vec++; if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin n_err++;
            $display("FAIL cold_perf got %0d/%0d want 0/0", perf_branches, perf_mispredicts); end
    endtask

    task automatic test_jal();
        do_reset();
        do_update(1'b0, 1'b1, 32'h200, 32'h480, 8'h00, 1'b0);
        F_pc = 32'h200; #1;
        n_vec++; if (F_btb_hit !== 1'b1) begin n_err++;
            $display("FAIL jal_hit got %0b want 1", F_btb_hit); end
        n_vec++; if (F_pred_taken !== 1'b1) begin n_err++;
            $display("FAIL jal_taken got %0b want 1", F_pred_taken); end
        n_vec++; if (F_pred_pc !== 32'h480) begin n_err++;
            $display("FAIL jal_pred_pc got %h want 00000480", F_pred_pc); end
        n_vec++; if (F_pht_idx !== 8'h80) begin n_err++;
            $display("FAIL jal_idx got %h want 80", F_pht_idx); end
    endtask

    // Counter at 0xC0 trained with a fixed index; observed later through a second
    // branch whose PC xor the final GHR lands back on 0xC0.
    task automatic test_cond_saturation();
        do_reset();
        F_pc = 32'h300; #1;
        n_vec++; if (F_pht_idx !== 8'hC0) begin n_err++;
            $display("FAIL cond_idx0 got %h want c0", F_pht_idx); end
        do_update(1'b1, 1'b1, 32'h300, 32'h380, 8'hC0, 1'b0);   // PHT[C0]=10, GHR=01
        #1;
        n_vec++; if (F_btb_hit !== 1'b1 || F_pht_idx !== 8'hC1) begin n_err++;
            $display("FAIL cond_first got hit=%0b idx=%h want hit=1 idx=c1",
                     F_btb_hit, F_pht_idx); end
        n_vec++; if (F_pred_taken !== 1'b0 || F_pred_pc !== 32'h304) begin n_err++;
            $display("FAIL cond_first_pred got %0b/%h want 0/00000304",
                     F_pred_taken, F_pred_pc); end
        for (int k = 0; k < 3; k++) do_update(1'b1, 1'b1, 32'h300, 32'h380, 8'hC0, 1'b0);
        do_update(1'b1, 1'b0, 32'h300, 32'h380, 8'hC0, 1'b0);   // 11 -> 10, GHR=1E
        do_update(1'b1, 1'b1, 32'h3F4, 32'h5000, 8'h00, 1'b0);  // GHR=3D, BTB[3D] set
        F_pc = 32'h3F4; #1;
        n_vec++; if (F_pht_idx !== 8'hC0) begin n_err++;
            $display("FAIL cond_obs_idx got %h want c0", F_pht_idx); end
        n_vec++; if (F_pred_taken !== 1'b1 || F_pred_pc !== 32'h5000) begin n_err++;
            $display("FAIL cond_sat got %0b/%h want 1/00005000", F_pred_taken, F_pred_pc); end
        F_pc = 32'h300; #1;
        n_vec++; if (F_btb_target !== 32'h380) begin n_err++;
            $display("FAIL cond_nt_btb got %h want 00000380", F_btb_target); end
    endtask

    task automatic test_alias();
        do_reset();
        do_update(1'b0, 1'b1, 32'h104, 32'h900, 8'h00, 1'b0);
        do_update(1'b0, 1'b1, 32'h10104, 32'hA00, 8'h00, 1'b0);
        F_pc = 32'h104; #1;
        n_vec++; if (F_btb_hit !== 1'b0 || F_pred_pc !== 32'h108) begin n_err++;
            $display("FAIL alias_old got %0b/%h want 0/00000108", F_btb_hit, F_pred_pc); end
        n_vec++; if (F_btb_target !== 32'h0) begin n_err++;
            $display("FAIL alias_old_tgt got %h want 0", F_btb_target); end
        F_pc = 32'h10104; #1;
        n_vec++; if (F_btb_hit !== 1'b1 || F_pred_pc !== 32'hA00) begin n_err++;
            $display("FAIL alias_new got %0b/%h want 1/00000a00", F_btb_hit, F_pred_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        F_pc             = 32'h400;
        ex_update_en     = 1'b1;
        ex_is_cond       = 1'b0;
        ex_actual_taken  = 1'b1;
        ex_pc            = 32'h400;
        ex_actual_target = 32'h444;
        ex_pht_idx       = 8'h00;
        #1;
        n_vec++; if (F_btb_hit !== 1'b0 || F_pred_pc !== 32'h404) begin n_err++;
            $display("FAIL hazard_same got %0b/%h want 0/00000404", F_btb_hit, F_pred_pc); end
        @(posedge clk); #1;
        ex_update_en = 1'b0;
        n_vec++; if (F_btb_hit !== 1'b1 || F_pred_pc !== 32'h444) begin n_err++;
            $display("FAIL hazard_next got %0b/%h want 1/00000444", F_btb_hit, F_pred_pc); end
    endtask

    task automatic test_perf_reset();
        do_reset();
        do_update(1'b1, 1'b0, 32'h500, 32'h0, 8'h40, 1'b1);
        do_update(1'b1, 1'b0, 32'h500, 32'h0, 8'h40, 1'b0);
        do_update(1'b0, 1'b1, 32'h580, 32'h800, 8'h00, 1'b1);
        ex_mispredict = 1'b1;                    // no update_en: must be ignored
        @(posedge clk); #1;
        ex_mispredict = 1'b0;
        n_vec++; if (perf_branches !== 32'd3 || perf_mispredicts !== 32'd2) begin n_err++;
            $display("FAIL perf got %0d/%0d want 3/2", perf_branches, perf_mispredicts); end
        rst = 1'b1;
        do_update(1'b0, 1'b1, 32'h600, 32'h700, 8'h00, 1'b1);
        rst = 1'b0;
        F_pc = 32'h600; #1;
        n_vec++; if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin n_err++;
            $display("FAIL rst_perf got %0d/%0d want 0/0", perf_branches, perf_mispredicts); end
        n_vec++; if (F_btb_hit !== 1'b0 || F_pred_pc !== 32'h604) begin n_err++;
            $display("FAIL rst_drop got %0b/%h want 0/00000604", F_btb_hit, F_pred_pc); end
        F_pc = 32'h580; #1;
        n_vec++; if (F_btb_hit !== 1'b0 || F_pht_idx !== 8'h60) begin n_err++;
            $display("FAIL rst_cold got %0b/%h want 0/60", F_btb_hit, F_pht_idx); end
    endtask

    initial begin
        rst              = 1'b1;
        F_pc             = 32'h0;
        ex_update_en     = 1'b0;
        ex_is_cond       = 1'b0;
        ex_actual_taken  = 1'b0;
        ex_pc            = 32'h0;
        ex_actual_target = 32'h0;
        ex_pht_idx       = 8'h0;
        ex_mispredict    = 1'b0;
        test_reset();
        test_jal();
        test_cond_saturation();
        test_alias();
        test_back_to_back();
        test_perf_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
